channel_accumulator: RTL

Sequential consumer of the adder tree's `o_data`/`o_valid` stream in the convolution datapath. It sums `NUM_ACCUM` consecutive valid partial sums, one per input-channel slice of a kernel window. It adds a per-output-channel bias on the first beat of each group and emits one registered, sign-extended result per group with a single-cycle valid pulse. There is no backpressure: the block accepts a beat on every cycle that `i_valid` is high.

---
 rtl/channel_accumulator_pkg.sv | 28 ++
 rtl/channel_accumulator.sv | 70 +++++++
 2 files changed

// File: rtl/channel_accumulator_pkg.sv
// Shared datapath width rules for the convolution pipeline.
// Holds max(), adder-tree output width and accumulator width helpers.
package channel_accumulator_pkg;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Adder tree summing n_in operands of in_w bits.
    function automatic int tree_out_width(input int in_w, input int n_in);
        return in_w + $clog2(n_in);
    endfunction

    // Group sum of n partial sums plus a bias, with one guard bit.
    function automatic int acc_width(
        input int in_w,
        input int bias_w,
        input int n
    );
        return max_int(tree_out_width(in_w, n), bias_w) + 1;
    endfunction

    // Beat counter needs at least one bit even when n == 1.
    function automatic int cnt_width(input int n);
        return max_int(1, $clog2(n));
    endfunction

endpackage

// File: rtl/channel_accumulator.sv
// Sums NUM_ACCUM valid partial sums plus a first-beat bias per group.
// Ports: clk, rst (async high), i_data/i_valid/i_bias/i_clear in,
//        o_data (signed group result) and o_valid (1-cycle pulse) out.
module channel_accumulator
    import channel_accumulator_pkg::*;
#(
    parameter  int IN_WIDTH   = 21,
    parameter  int BIAS_WIDTH = 16,
    parameter  int NUM_ACCUM  = 8,
    localparam int ACC_WIDTH  = acc_width(IN_WIDTH, BIAS_WIDTH, NUM_ACCUM)
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic signed [ACC_WIDTH-1:0] o_data,
    output logic                        o_valid,
    input  logic signed [IN_WIDTH-1:0]  i_data,
    input  logic                        i_valid,
    input  logic signed [BIAS_WIDTH-1:0] i_bias,
    input  logic                        i_clear
);

    localparam int CNT_W = cnt_width(NUM_ACCUM);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ACCUM - 1);

    logic [CNT_W-1:0]            r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_data;
    logic                        r_valid;

    logic [CNT_W-1:0]            w_idx;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic                        w_last;

    always_comb begin
        // A clear turns the current beat into beat 0 of a new group.
        w_idx     = i_clear ? '0 : r_cnt;
        w_base    = (w_idx == '0) ? ACC_WIDTH'(i_bias) : r_acc;
        w_sum     = w_base + ACC_WIDTH'(i_data);
        // The beat that carries a clear never completes a group.
        w_last    = !i_clear && (w_idx == LAST);
        w_cnt_nxt = (w_idx == LAST) ? '0 : w_idx + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_valid) begin
                r_cnt <= w_cnt_nxt;
                r_acc <= w_sum;
                if (w_last) begin
                    r_data  <= w_sum;
                    r_valid <= 1'b1;
                end
            end else if (i_clear) begin
                r_cnt <= '0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
